// File: rtl/uart_sched_pkg.sv
// ============================================================================
//  Module      : uart_sched_pkg
//  Description : Shared constants, FSM state type and arbitration helper for
//                the UART transmit scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_sched_pkg;

   // UART register offsets on the MMIO bus
   localparam logic [3:0] UART_RDR_OFS = 4'h4;
   localparam logic [3:0] UART_TDR_OFS = 4'h8;
   localparam logic [3:0] UART_SSR_OFS = 4'hC;

   // SSR bit positions
   localparam int SSR_TXEN   = 0;
   localparam int SSR_RXRDY  = 1;
   localparam int SSR_RXBUSY = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_POLL  = 2'd1,
      S_WRITE = 2'd2
   } sched_state_t;

   // Round-robin choice between two queues; the caller guarantees at least one is non-empty.
   function automatic logic rr_pick(input logic ne0, input logic ne1, input logic last);
      if (ne0 && ne1) begin
         return ~last;
      end
      return ~ne0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sched_fifo.sv
// ============================================================================
//  Module      : uart_sched_fifo
//  Description : Synchronous byte FIFO with occupancy count and head peek.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_sched_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [7:0]               i_data,
   input  logic                     i_pop,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic [7:0]               o_head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] cnt_q,  cnt_d;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (cnt_q == CW'(DEPTH));
   assign o_empty = (cnt_q == '0);
   assign o_count = cnt_q;
   assign o_head  = mem_q[rptr_q];

   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop  && !o_empty;

   // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (w_push) begin
         mem_d[wptr_q] = i_data;
         wptr_d        = wptr_q + 1'b1;
      end
      if (w_pop) begin
         rptr_d = rptr_q + 1'b1;
      end
      case ({w_push, w_pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// ============================================================================
//  Module      : uart_tx_scheduler
//  Description : Buffers two byte streams, arbitrates between them and drives
//                the UART MMIO bus (poll SSR.tx_enable, then write TDR).
//                Define UART_SCHED_PRIO_EN for strict port-0 priority;
//                otherwise arbitration is round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_scheduler
   import uart_sched_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic                                clk_in,
   input  logic                                rst_in,
   input  logic [1:0]                          req_valid,
   input  logic [1:0][7:0]                     req_data,
   output logic [1:0]                          req_ready,
   output logic [1:0][$clog2(FIFO_DEPTH):0]    fifo_cnt,
   output logic                                uart_cs,
   output logic                                uart_we,
   output logic [3:0]                          uart_addr,
   output logic [31:0]                         uart_wdata,
   input  logic [31:0]                         uart_rdata,
   output logic                                idle
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   sched_state_t    state_q, state_d;
   logic            grant_q, grant_d;
   logic [7:0]      byte_q,  byte_d;

   logic [1:0]      w_full;
   logic [1:0]      w_empty;
   logic [1:0][7:0] w_head;
   logic [1:0]      w_pop;
   logic            w_any;
   logic            w_remain;
   logic            w_pick;
   logic            w_txen;
   logic            w_rdata_unused;

   generate
      for (genvar i = 0; i < 2; i++) begin : g_fifo
         uart_sched_fifo #(
            .DEPTH (FIFO_DEPTH)
         ) u_fifo (
            .clk     (clk_in),
            .rst     (rst_in),
            .i_push  (req_valid[i] && req_ready[i]),
            .i_data  (req_data[i]),
            .i_pop   (w_pop[i]),
            .o_full  (w_full[i]),
            .o_empty (w_empty[i]),
            .o_count (fifo_cnt[i]),
            .o_head  (w_head[i])
         );
         assign req_ready[i] = ~w_full[i];
      end
   endgenerate

   assign w_any          = ~(&w_empty);
   assign w_txen         = uart_rdata[SSR_TXEN];
   assign w_rdata_unused = ^uart_rdata[31:1];
   assign idle           = (state_q == S_IDLE) && (&w_empty);

   // Bytes left once the current write pops its queue; a same-cycle push is not counted.
   assign w_remain = (fifo_cnt[grant_q] > CW'(1)) || !w_empty[~grant_q];

`ifdef UART_SCHED_PRIO_EN
   assign w_pick = w_empty[0];
`else
   logic last_grant_q, last_grant_d;

   always_comb begin
      last_grant_d = last_grant_q;
      if (state_q == S_WRITE) begin
         last_grant_d = grant_q;
      end
   end

   // Resetting to port 1 hands the first tie to port 0.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

   assign w_pick = rr_pick(~w_empty[0], ~w_empty[1], last_grant_q);
`endif

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= S_IDLE;
         grant_q <= 1'b0;
         byte_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         byte_q  <= byte_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      byte_d  = byte_q;
      unique case (state_q)
         S_IDLE: begin
            if (w_any) begin
               state_d = S_POLL;
            end
         end
         S_POLL: begin
            if (!w_any) begin
               state_d = S_IDLE;
            end else if (w_txen) begin
               grant_d = w_pick;
               byte_d  = w_head[w_pick];
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            state_d = w_remain ? S_POLL : S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      uart_cs    = 1'b0;
      uart_we    = 1'b0;
      uart_addr  = 4'h0;
      uart_wdata = 32'h0;
      w_pop      = 2'b00;
      unique case (state_q)
         S_POLL: begin
            uart_cs   = 1'b1;
            uart_addr = UART_SSR_OFS;
         end
         S_WRITE: begin
            uart_cs        = 1'b1;
            uart_we        = 1'b1;
            uart_addr      = UART_TDR_OFS;
            uart_wdata     = {24'h0, byte_q};
            w_pop[grant_q] = 1'b1;
         end
         default: begin
            uart_cs = 1'b0;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
// ============================================================================
//  Module      : tb_uart_tx_scheduler
//  Description : Self-checking bench for uart_tx_scheduler with a queue-based
//                reference model and directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_scheduler;

   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic                 clk_in = 1'b0;
   logic                 rst_in = 1'b1;
   logic [1:0]           req_valid = '0;
   logic [1:0][7:0]      req_data  = '0;
   logic [1:0]           req_ready;
   logic [1:0][CW-1:0]   fifo_cnt;
   logic                 uart_cs;
   logic                 uart_we;
   logic [3:0]           uart_addr;
   logic [31:0]          uart_wdata;
   logic [31:0]          uart_rdata;
   logic                 idle;
   logic                 txen = 1'b1;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model: per-port byte queues plus the bus operation expected this cycle
   // (0 = bus idle, 1 = SSR read, 2 = TDR write).
   logic [7:0] mq0[$];
   logic [7:0] mq1[$];
   int         m_op   = 0;
   int         m_g    = 0;
   int         m_last = 1;
   logic [7:0] m_byte = 8'h00;
   bit         chk_en = 1'b0;

   logic [7:0] wr_log[$];
   int         wr_cyc[$];

   uart_tx_scheduler #(
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .fifo_cnt   (fifo_cnt),
      .uart_cs    (uart_cs),
      .uart_we    (uart_we),
      .uart_addr  (uart_addr),
      .uart_wdata (uart_wdata),
      .uart_rdata (uart_rdata),
      .idle       (idle)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   // SSR model: rx bits set so that only bit 0 may gate the write.
   assign uart_rdata = (uart_cs && !uart_we && uart_addr == 4'hC) ?
                       (32'hA5A5_A5A6 | {31'b0, txen}) : 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int pick(input int s0, input int s1, input int last);
`ifdef UART_SCHED_PRIO_EN
      if (s0 + s1 + last < 0) return 1;
      return (s0 > 0) ? 0 : 1;
`else
      if (s0 > 0 && s1 > 0) return 1 - last;
      return (s0 > 0) ? 0 : 1;
`endif
   endfunction

   task automatic compare();
      chk("cs",     32'(uart_cs),   32'(m_op != 0));
      chk("we",     32'(uart_we),   32'(m_op == 2));
      chk("addr",   32'(uart_addr), (m_op == 0) ? 32'h0 : (m_op == 1) ? 32'hC : 32'h8);
      chk("wdata",  uart_wdata,     (m_op == 2) ? {24'h0, m_byte} : 32'h0);
      chk("idle",   32'(idle),      32'(m_op == 0 && mq0.size() == 0 && mq1.size() == 0));
      chk("ready0", 32'(req_ready[0]), 32'(mq0.size() < DEPTH));
      chk("ready1", 32'(req_ready[1]), 32'(mq1.size() < DEPTH));
      chk("cnt0",   32'(fifo_cnt[0]),  32'(mq0.size()));
      chk("cnt1",   32'(fifo_cnt[1]),  32'(mq1.size()));
      if (uart_cs && uart_we && uart_addr == 4'h8) begin
         wr_log.push_back(uart_wdata[7:0]);
         wr_cyc.push_back(cyc);
      end
   endtask

   task automatic model_step();
      int  s0;
      int  s1;
      bit  p0;
      bit  p1;
      if (rst_in) begin
         mq0.delete();
         mq1.delete();
         m_op   = 0;
         m_last = 1;
         return;
      end
      s0 = mq0.size();
      s1 = mq1.size();
      p0 = req_valid[0] && (s0 < DEPTH);
      p1 = req_valid[1] && (s1 < DEPTH);
      case (m_op)
         0: m_op = (s0 + s1 > 0) ? 1 : 0;
         1: begin
            if (s0 + s1 == 0) begin
               m_op = 0;
            end else if (txen) begin
               m_g    = pick(s0, s1, m_last);
               m_byte = (m_g == 0) ? mq0[0] : mq1[0];
               m_op   = 2;
            end
         end
         default: begin
            if (m_g == 0 && mq0.size() > 0) void'(mq0.pop_front());
            if (m_g == 1 && mq1.size() > 0) void'(mq1.pop_front());
            m_last = m_g;
            m_op   = (mq0.size() + mq1.size() > 0) ? 1 : 0;
         end
      endcase
      if (p0) mq0.push_back(req_data[0]);
      if (p1) mq1.push_back(req_data[1]);
   endtask

   initial begin
      forever begin
         @(negedge clk_in);
         if (chk_en) compare();
         model_step();
         chk_en = 1'b1;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      req_valid = '0;
      rst_in    = 1'b1;
      tick();
      tick();
      rst_in = 1'b0;
      wr_log.delete();
      wr_cyc.delete();
   endtask

   task automatic push(input int port, input logic [7:0] d);
      req_valid[port] = 1'b1;
      req_data[port]  = d;
      tick();
      req_valid = '0;
   endtask

   task automatic wait_writes(input int n, input int budget);
      int k = 0;
      while (wr_log.size() < n && k < budget) begin
         tick();
         k++;
      end
      chk("write_count_reached", 32'(wr_log.size() >= n), 32'h1);
   endtask

   task automatic wait_bus(input bit we, input int budget, output bit ok);
      int k = 0;
      while (!(uart_cs && uart_we == we) && k < budget) begin
         tick();
         k++;
      end
      ok = uart_cs && (uart_we == we);
      chk("bus_event_reached", 32'(ok), 32'h1);
   endtask

   initial begin
      int t;
      int polls;
      bit ok;

      // 1: single byte, latency and return to idle
      do_reset();
      txen = 1'b1;
      chk("rst_cs",    32'(uart_cs),   32'h0);
      chk("rst_we",    32'(uart_we),   32'h0);
      chk("rst_addr",  32'(uart_addr), 32'h0);
      chk("rst_wdata", uart_wdata,     32'h0);
      chk("rst_ready", 32'(req_ready), 32'h3);
      chk("rst_cnt",   32'(fifo_cnt),  32'h0);
      chk("rst_idle",  32'(idle),      32'h1);
      req_valid[0] = 1'b1;
      req_data[0]  = 8'h41;
      t = cyc;
      tick();
      req_valid = '0;
      wait_writes(1, 20);
      chk("t1_byte",    32'(wr_log[0]),  32'h41);
      chk("t1_latency", 32'(wr_cyc[0] - t), 32'd3);
      chk("t1_idle_after", 32'(idle), 32'h1);
      repeat (5) tick();
      chk("t1_single_write", 32'(wr_log.size()), 32'd1);

      // 2: interleaving of two queued streams
      do_reset();
      txen = 1'b0;
      req_valid   = 2'b11;
      req_data[0] = 8'h10;
      req_data[1] = 8'h20;
      tick();
      req_data[0] = 8'h11;
      req_data[1] = 8'h21;
      tick();
      req_valid = '0;
      tick();
      txen = 1'b1;
      wait_writes(4, 50);
`ifdef UART_SCHED_PRIO_EN
      chk("t2_w0", 32'(wr_log[0]), 32'h10);
      chk("t2_w1", 32'(wr_log[1]), 32'h11);
      chk("t2_w2", 32'(wr_log[2]), 32'h20);
      chk("t2_w3", 32'(wr_log[3]), 32'h21);
`else
      chk("t2_w0", 32'(wr_log[0]), 32'h10);
      chk("t2_w1", 32'(wr_log[1]), 32'h20);
      chk("t2_w2", 32'(wr_log[2]), 32'h11);
      chk("t2_w3", 32'(wr_log[3]), 32'h21);
`endif

      // 3: 50 polls with tx_enable low, write on the cycle after it rises
      do_reset();
      txen = 1'b0;
      push(0, 8'h55);
      wait_bus(1'b0, 10, ok);
      polls = 0;
      repeat (50) begin
         if (uart_cs && !uart_we && uart_addr == 4'hC) polls++;
         tick();
      end
      txen = 1'b1;
      t = cyc;
      chk("t3_polls",    32'(polls),         32'd50);
      chk("t3_no_write", 32'(wr_log.size()), 32'd0);
      wait_writes(1, 10);
      chk("t3_latency", 32'(wr_cyc[0] - t), 32'd1);
      chk("t3_byte",    32'(wr_log[0]),     32'h55);

      // 4: overfill port 1, then drain in order
      do_reset();
      txen = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         req_valid[1] = 1'b1;
         req_data[1]  = 8'h30 + 8'(i);
         if (i == DEPTH) chk("t4_ready_when_full", 32'(req_ready[1]), 32'h0);
         tick();
      end
      req_valid = '0;
      chk("t4_cnt_full",   32'(fifo_cnt[1]),  32'd8);
      chk("t4_ready_full", 32'(req_ready[1]), 32'h0);
      txen = 1'b1;
      wait_writes(8, 60);
      for (int i = 0; i < DEPTH; i++) begin
         chk("t4_order", 32'(wr_log[i]), 32'h30 + 32'(i));
      end
      repeat (5) tick();
      chk("t4_ninth_dropped", 32'(wr_log.size()), 32'd8);
      chk("t4_cnt_drained",   32'(fifo_cnt[1]),   32'd0);

      // 5: reset while a write is on the bus with bytes pending
      do_reset();
      txen = 1'b1;
      push(0, 8'h61);
      push(0, 8'h62);
      push(0, 8'h63);
      wait_bus(1'b1, 10, ok);
      rst_in = 1'b1;
      tick();
      chk("t5_cs",   32'(uart_cs),  32'h0);
      chk("t5_we",   32'(uart_we),  32'h0);
      chk("t5_cnt",  32'(fifo_cnt), 32'h0);
      chk("t5_idle", 32'(idle),     32'h1);
      rst_in = 1'b0;
      repeat (10) tick();
      chk("t5_no_more_writes", 32'(wr_log.size()), 32'd1);

      // 6: push and pop in the same cycle across the pointer wrap
      do_reset();
      txen = 1'b1;
      for (int i = 0; i < 6; i++) push(0, 8'h70 + 8'(i));
      wait_writes(6, 60);
      repeat (3) tick();
      txen = 1'b0;
      push(0, 8'hA0);
      push(0, 8'hA1);
      push(0, 8'hA2);
      chk("t6_cnt_pre", 32'(fifo_cnt[0]), 32'd3);
      txen = 1'b1;
      wait_bus(1'b1, 5, ok);
      chk("t6_cnt_at_write", 32'(fifo_cnt[0]), 32'd3);
      req_valid[0] = 1'b1;
      req_data[0]  = 8'hA3;
      tick();
      req_valid = '0;
      chk("t6_cnt_after", 32'(fifo_cnt[0]), 32'd3);
      wait_writes(10, 40);
      chk("t6_w0", 32'(wr_log[6]), 32'hA0);
      chk("t6_w1", 32'(wr_log[7]), 32'hA1);
      chk("t6_w2", 32'(wr_log[8]), 32'hA2);
      chk("t6_w3", 32'(wr_log[9]), 32'hA3);

      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
